// File: rtl/tile_pkg.sv
// Shared definitions for the player core: tile codes as stored in the map BRAM
// (low byte of each word) and the move FSM state encoding.
package tile_pkg;

    // Tile type codes, data[7:0] of a map word; data[15:8] carries the argument.
    localparam logic [7:0] TileEmpty     = 8'h00;
    localparam logic [7:0] TileWall      = 8'h01;
    localparam logic [7:0] TileKeyBase   = 8'h02;  // KEY_k   = TileKeyBase + k
    localparam logic [7:0] TileDoorBase  = 8'h10;  // DOOR_k  = TileDoorBase + k
    localparam logic [7:0] TilePotion    = 8'h20;
    localparam logic [7:0] TileMonster   = 8'h30;
    localparam logic [7:0] TileStairUp   = 8'h40;
    localparam logic [7:0] TileStairDown = 8'h41;

    localparam logic [15:0] TileCleared  = 16'h0000;

    // Move FSM: IDLE -> READ -> DECIDE -> (WRITE) -> IDLE, DEAD absorbing.
    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRead   = 3'd1,
        StDecide = 3'd2,
        StWrite  = 3'd3,
        StDead   = 3'd4
    } state_e;

endpackage

// File: rtl/player_core_if.sv
// Map BRAM bus between the player core and a single-port RAM with 1-cycle read latency.
//   bram_addr   word address (floor*MAP_W*MAP_H + y*MAP_W + x)
//   bram_data   read data, valid the cycle after the address is presented
//   bram_wr     write strobe
//   bram_dwrite write data
// master: the player core; slave: the memory.
interface player_core_if #(
    parameter int unsigned ADDR_W = 19
);
    logic [ADDR_W-1:0] bram_addr;
    logic [15:0]       bram_data;
    logic              bram_wr;
    logic [15:0]       bram_dwrite;

    modport master (
        output bram_addr,
        output bram_wr,
        output bram_dwrite,
        input  bram_data
    );

    modport slave (
        input  bram_addr,
        input  bram_wr,
        input  bram_dwrite,
        output bram_data
    );
endinterface

// File: rtl/player_target.sv
// Combinational target calculation for a move request.
//   x_i, y_i, floor_i  current player position
//   move_i             direction request: bit0 up, bit1 down, bit2 left, bit3 right
//   tx_o, ty_o         target coordinates (equal to current on an invalid request)
//   addr_o             map word address of the target tile
//   valid_o            request is one-hot and the target lies on the grid
module player_target #(
    parameter int unsigned MAP_W   = 13,
    parameter int unsigned MAP_H   = 13,
    parameter int unsigned COORD_W = 4,
    parameter int unsigned ADDR_W  = 19
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [15:0]        floor_i,
    input  logic [3:0]         move_i,
    output logic [COORD_W-1:0] tx_o,
    output logic [COORD_W-1:0] ty_o,
    output logic [ADDR_W-1:0]  addr_o,
    output logic               valid_o
);

    always_comb begin
        tx_o    = x_i;
        ty_o    = y_i;
        valid_o = 1'b0;
        // Zero or multi-bit requests fall to default and are never valid.
        case (move_i)
            4'b0001: begin
                ty_o    = y_i - COORD_W'(1);
                valid_o = (y_i != '0);
            end
            4'b0010: begin
                ty_o    = y_i + COORD_W'(1);
                valid_o = (32'(y_i) < MAP_H - 1);
            end
            4'b0100: begin
                tx_o    = x_i - COORD_W'(1);
                valid_o = (x_i != '0);
            end
            4'b1000: begin
                tx_o    = x_i + COORD_W'(1);
                valid_o = (32'(x_i) < MAP_W - 1);
            end
            default: valid_o = 1'b0;
        endcase
    end

    assign addr_o = ADDR_W'(32'(floor_i) * MAP_W * MAP_H + 32'(ty_o) * MAP_W + 32'(tx_o));

endmodule

// File: rtl/player_core.sv
// Tile-based player movement engine.
//   clk, rstn           clock, asynchronous active-low reset
//   move_i              direction request (bit0 up, bit1 down, bit2 left, bit3 right),
//                       acted on at a one-hot change while idle
//   cheat_hp_i          +1 health per idle cycle (priority over cheat_key_i)
//   cheat_key_i         +1 to every key counter per idle cycle
//   player_x_o/_y_o     position; floor_o current floor
//   health_o            health; key_num_o key counters, type k at [k*KEY_W +: KEY_W]
//   busy_o              move in progress; dead_o health reached 0
//   bram                map BRAM master port
// A move reads the target tile (READ), acts on it (DECIDE) and, for consumable
// tiles, clears it (WRITE).
module player_core
    import tile_pkg::*;
#(
    parameter int unsigned MAP_W     = 13,
    parameter int unsigned MAP_H     = 13,
    parameter int unsigned COORD_W   = 4,
    parameter int unsigned FLOORS    = 16,
    parameter int unsigned KEY_TYPES = 4,
    parameter int unsigned KEY_W     = 8,
    parameter int unsigned HP_W      = 16,
    parameter int unsigned ADDR_W    = 19,
    parameter int unsigned START_X   = 6,
    parameter int unsigned START_Y   = 10,
    parameter int unsigned START_HP  = 20
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [3:0]                  move_i,
    input  logic                        cheat_hp_i,
    input  logic                        cheat_key_i,
    output logic [COORD_W-1:0]          player_x_o,
    output logic [COORD_W-1:0]          player_y_o,
    output logic [15:0]                 floor_o,
    output logic [HP_W-1:0]             health_o,
    output logic [KEY_TYPES*KEY_W-1:0]  key_num_o,
    output logic                        busy_o,
    output logic                        dead_o,
    player_core_if.master               bram
);

    typedef logic [KEY_TYPES-1:0][KEY_W-1:0] keys_t;

    state_e              state_q, state_d;
    logic [3:0]          move_q;
    logic [COORD_W-1:0]  x_q, x_d, y_q, y_d;
    logic [COORD_W-1:0]  tx_q, tx_d, ty_q, ty_d;
    logic [15:0]         floor_q, floor_d;
    logic [HP_W-1:0]     health_q, health_d;
    keys_t               keys_q, keys_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [COORD_W-1:0]  tgt_x, tgt_y;
    logic [ADDR_W-1:0]   tgt_addr;
    logic                tgt_valid;
    logic                move_accept;
    logic [7:0]          tile, arg;
    logic                do_move, do_clear;

    function automatic logic [HP_W-1:0] hp_add(input logic [HP_W-1:0] a, input logic [7:0] b);
        logic [HP_W:0] sum;
        sum = {1'b0, a} + (HP_W+1)'(b);
        return sum[HP_W] ? {HP_W{1'b1}} : sum[HP_W-1:0];
    endfunction

    function automatic logic [KEY_W-1:0] key_inc(input logic [KEY_W-1:0] a);
        return (a == {KEY_W{1'b1}}) ? a : a + KEY_W'(1);
    endfunction

    player_target #(
        .MAP_W   (MAP_W),
        .MAP_H   (MAP_H),
        .COORD_W (COORD_W),
        .ADDR_W  (ADDR_W)
    ) u_target (
        .x_i     (x_q),
        .y_i     (y_q),
        .floor_i (floor_q),
        .move_i  (move_i),
        .tx_o    (tgt_x),
        .ty_o    (tgt_y),
        .addr_o  (tgt_addr),
        .valid_o (tgt_valid)
    );

    // Only a change of the request starts a move, so a held direction steps once.
    assign move_accept = (state_q == StIdle) && (move_i != move_q) && tgt_valid;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        floor_d  = floor_q;
        health_d = health_q;
        keys_d   = keys_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        addr_d   = addr_q;
        tile     = bram.bram_data[7:0];
        arg      = bram.bram_data[15:8];
        do_move  = 1'b0;
        do_clear = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (move_accept) begin
                    tx_d    = tgt_x;
                    ty_d    = tgt_y;
                    addr_d  = tgt_addr;
                    state_d = StRead;
                end else if (cheat_hp_i) begin
                    health_d = hp_add(health_q, 8'd1);
                end else if (cheat_key_i) begin
                    for (int k = 0; k < int'(KEY_TYPES); k++) begin
                        keys_d[k] = key_inc(keys_q[k]);
                    end
                end
            end

            StRead: state_d = StDecide;

            StDecide: begin
                state_d = StIdle;
                for (int k = 0; k < int'(KEY_TYPES); k++) begin
                    if (tile == TileKeyBase + 8'(k)) begin
                        keys_d[k] = key_inc(keys_q[k]);
                        do_move   = 1'b1;
                        do_clear  = 1'b1;
                    end
                    if ((tile == TileDoorBase + 8'(k)) && (keys_q[k] != '0)) begin
                        keys_d[k] = keys_q[k] - KEY_W'(1);
                        do_move   = 1'b1;
                        do_clear  = 1'b1;
                    end
                end
                case (tile)
                    TileEmpty: do_move = 1'b1;
                    TileWall:  ;
                    TilePotion: begin
                        health_d = hp_add(health_q, arg);
                        do_move  = 1'b1;
                        do_clear = 1'b1;
                    end
                    TileMonster: begin
                        if (32'(arg) >= 32'(health_q)) begin
                            // Fatal fight: player stays put and the monster remains.
                            health_d = '0;
                            state_d  = StDead;
                        end else begin
                            health_d = health_q - HP_W'(arg);
                            do_move  = 1'b1;
                            do_clear = 1'b1;
                        end
                    end
                    TileStairUp: begin
                        if (32'(floor_q) < FLOORS - 1) floor_d = floor_q + 16'd1;
                    end
                    TileStairDown: begin
                        if (floor_q != 16'd0) floor_d = floor_q - 16'd1;
                    end
                    // Keys/doors handled above; anything else blocks like a wall.
                    default: ;
                endcase
                if (do_move) begin
                    x_d = tx_q;
                    y_d = ty_q;
                end
                if (do_clear) state_d = StWrite;
            end

            StWrite: state_d = StIdle;

            StDead: state_d = StDead;

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            move_q   <= '0;
            x_q      <= COORD_W'(START_X);
            y_q      <= COORD_W'(START_Y);
            tx_q     <= '0;
            ty_q     <= '0;
            floor_q  <= '0;
            health_q <= HP_W'(START_HP);
            keys_q   <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            move_q   <= move_i;  // sampled every cycle, busy or not
            x_q      <= x_d;
            y_q      <= y_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            floor_q  <= floor_d;
            health_q <= health_d;
            keys_q   <= keys_d;
            addr_q   <= addr_d;
        end
    end

    assign player_x_o       = x_q;
    assign player_y_o       = y_q;
    assign floor_o          = floor_q;
    assign health_o         = health_q;
    assign key_num_o        = keys_q;
    assign busy_o           = (state_q == StRead) || (state_q == StDecide) || (state_q == StWrite);
    assign dead_o           = (state_q == StDead);
    assign bram.bram_addr   = addr_q;
    assign bram.bram_wr     = (state_q == StWrite);
    assign bram.bram_dwrite = TileCleared;

endmodule

// File: tb/tb_player_core.sv
// Self-checking bench for player_core: a vector table of moves over a modelled map
// BRAM, expected tile clears queued and matched against observed writes, plus
// hand sequences for cheats, death and reset during a write.
module tb_player_core;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [3:0]  move_i = '0;
    logic        cheat_hp_i = 1'b0;
    logic        cheat_key_i = 1'b0;
    logic [3:0]  player_x_o, player_y_o;
    logic [15:0] floor_o, health_o;
    logic [31:0] key_num_o;
    logic        busy_o, dead_o;

    player_core_if #(.ADDR_W(19)) bif ();

    player_core dut (
        .clk         (clk),
        .rstn        (rstn),
        .move_i      (move_i),
        .cheat_hp_i  (cheat_hp_i),
        .cheat_key_i (cheat_key_i),
        .player_x_o  (player_x_o),
        .player_y_o  (player_y_o),
        .floor_o     (floor_o),
        .health_o    (health_o),
        .key_num_o   (key_num_o),
        .busy_o      (busy_o),
        .dead_o      (dead_o),
        .bram        (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  dir;
        logic [15:0] tile;
        int          ex, ey, ef, ehp;
        logic [31:0] ekeys;
        bit          rd, wr, dead;
    } vec_t;

    logic [15:0] mem [0:4095];
    int          wr_q [$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cur_x = 6, cur_y = 10, cur_f = 0;
    vec_t        vecs [21];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Map BRAM: registered read, write taken mid-cycle while the strobe is stable.
    always @(posedge clk) bif.bram_data <= mem[bif.bram_addr[11:0]];

    always @(negedge clk) begin
        if (bif.bram_wr === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL bram_write: got write at %0d, expected none", bif.bram_addr);
            end else begin
                check("bram_waddr", 64'(bif.bram_addr), 64'(wr_q.pop_front()));
                check("bram_wdata", 64'(bif.bram_dwrite), 64'h0);
            end
            mem[bif.bram_addr[11:0]] = bif.bram_dwrite;
        end
    end

    function automatic bit tgt(input int x, input int y, input logic [3:0] d,
                               output int tx, output int ty);
        tx = x;
        ty = y;
        case (d)
            4'b0001: begin ty = y - 1; return y > 0;  end
            4'b0010: begin ty = y + 1; return y < 12; end
            4'b0100: begin tx = x - 1; return x > 0;  end
            4'b1000: begin tx = x + 1; return x < 12; end
            default: return 1'b0;
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        int tx, ty, a;
        bit ok;
        ok = tgt(cur_x, cur_y, v.dir, tx, ty);
        a  = cur_f * 169 + ty * 13 + tx;
        @(negedge clk);
        if (ok) mem[a[11:0]] = v.tile;
        if (v.wr) wr_q.push_back(a);
        move_i = v.dir;
        @(negedge clk);
        move_i = '0;
        check({tag, ".busy_read"}, 64'(busy_o), 64'(v.rd));
        @(negedge clk);
        @(negedge clk);
        check({tag, ".x"}, 64'(player_x_o), 64'(v.ex));
        check({tag, ".y"}, 64'(player_y_o), 64'(v.ey));
        check({tag, ".floor"}, 64'(floor_o), 64'(v.ef));
        check({tag, ".health"}, 64'(health_o), 64'(v.ehp));
        check({tag, ".keys"}, 64'(key_num_o), 64'(v.ekeys));
        check({tag, ".dead"}, 64'(dead_o), 64'(v.dead));
        check({tag, ".busy_write"}, 64'(busy_o), 64'(v.wr));
        @(negedge clk);
        check({tag, ".busy_idle"}, 64'(busy_o), 64'h0);
        cur_x = v.ex;
        cur_y = v.ey;
        cur_f = v.ef;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".x"}, 64'(player_x_o), 64'd6);
        check({tag, ".y"}, 64'(player_y_o), 64'd10);
        check({tag, ".floor"}, 64'(floor_o), 64'd0);
        check({tag, ".health"}, 64'(health_o), 64'd20);
        check({tag, ".keys"}, 64'(key_num_o), 64'd0);
        check({tag, ".dead"}, 64'(dead_o), 64'd0);
        check({tag, ".busy"}, 64'(busy_o), 64'd0);
        check({tag, ".bram_wr"}, 64'(bif.bram_wr), 64'd0);
        check({tag, ".bram_addr"}, 64'(bif.bram_addr), 64'd0);
        check({tag, ".bram_dwrite"}, 64'(bif.bram_dwrite), 64'd0);
    endtask

    task automatic cheat_cycles(input bit hp, input bit key, input int n);
        @(negedge clk);
        cheat_hp_i  = hp;
        cheat_key_i = key;
        repeat (n) @(negedge clk);
        cheat_hp_i  = 1'b0;
        cheat_key_i = 1'b0;
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

        //           dir      tile      x  y  f  hp  keys           rd    wr    dead
        vecs[0]  = '{4'b0001, 16'h0000, 6, 9, 0, 20, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'b0001, 16'h0003, 6, 8, 0, 20, 32'h0000_0100, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{4'b0100, 16'h0011, 5, 8, 0, 20, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{4'b0100, 16'h0012, 5, 8, 0, 20, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'b0010, 16'h0001, 5, 8, 0, 20, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'b1000, 16'h0077, 5, 8, 0, 20, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{4'b0011, 16'h0000, 5, 8, 0, 20, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b1000, 16'h0A20, 6, 8, 0, 30, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{4'b1000, 16'h0530, 7, 8, 0, 25, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{4'b0001, 16'h0041, 7, 8, 0, 25, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'b0001, 16'h0040, 7, 8, 1, 25, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{4'b0010, 16'h0041, 7, 8, 0, 25, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            vecs[12 + i] = '{4'b0100, 16'h0000, 6 - i, 8, 0, 25, 32'h0, 1'b1, 1'b0, 1'b0};
        end
        vecs[19] = '{4'b0100, 16'h0000, 0, 8, 0, 25, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{4'b0001, 16'h0002, 0, 7, 0, 25, 32'h0000_0001, 1'b1, 1'b1, 1'b0};

        #2 rstn = 1'b0;
        #1 check_reset("reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 21; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Cheats: hp +3, then both (hp wins) +2, then keys saturate.
        cheat_cycles(1'b1, 1'b0, 3);
        check("cheat_hp", 64'(health_o), 64'd28);
        cheat_cycles(1'b1, 1'b1, 2);
        check("cheat_prio.hp", 64'(health_o), 64'd30);
        check("cheat_prio.keys", 64'(key_num_o), 64'h0000_0001);
        cheat_cycles(1'b0, 1'b1, 300);
        check("cheat_key_sat", 64'(key_num_o), 64'hffff_ffff);

        v = '{4'b0010, 16'h0002, 0, 8, 0, 30, 32'hffff_ffff, 1'b1, 1'b1, 1'b0};
        run_vec(v, "key_sat");
        v = '{4'b1000, 16'h1E30, 0, 8, 0, 0, 32'hffff_ffff, 1'b1, 1'b0, 1'b1};
        run_vec(v, "monster_kill");
        v = '{4'b0001, 16'h0000, 0, 8, 0, 0, 32'hffff_ffff, 1'b0, 1'b0, 1'b1};
        run_vec(v, "dead_move");
        cheat_cycles(1'b1, 1'b0, 2);
        cheat_cycles(1'b0, 1'b1, 2);
        check("dead_cheat.hp", 64'(health_o), 64'd0);
        check("dead_cheat.keys", 64'(key_num_o), 64'hffff_ffff);
        check("dead_cheat.dead", 64'(dead_o), 64'd1);

        @(negedge clk);
        rstn = 1'b0;
        #1 check_reset("reset_dead");
        @(negedge clk);
        rstn  = 1'b1;
        cur_x = 6;
        cur_y = 10;
        cur_f = 0;

        // Reset while the KEY_3 tile clear is on the bus: the write must not land.
        @(negedge clk);
        mem[123] = 16'h0005;
        move_i   = 4'b0001;
        @(negedge clk);
        move_i = '0;
        check("abort.busy_read", 64'(busy_o), 64'd1);
        @(negedge clk);
        @(posedge clk);
        #1 check("abort.in_write", 64'(bif.bram_wr), 64'd1);
        rstn = 1'b0;
        #1 check_reset("abort");
        @(negedge clk);
        check("abort.tile_kept", 64'(mem[123]), 64'h0005);
        rstn = 1'b1;

        v = '{4'b0001, 16'h0000, 6, 9, 0, 20, 32'h0, 1'b1, 1'b0, 1'b0};
        run_vec(v, "after_abort");

        repeat (2) @(negedge clk);
        check("pending_writes", 64'(wr_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/player_core.md
PLAYER_CORE -- requirements
Module: player_core

Interface
REQ-001 SHALL have parameters: MAP_W=13 (grid columns), MAP_H=13 (grid rows), COORD_W=4 (coordinate bits), FLOORS=16 (floor count), KEY_TYPES=4 (key colours), KEY_W=8 (bits per key counter), HP_W=16 (health bits), ADDR_W=19 (map address bits), START_X=6, START_Y=10, START_HP=20.
REQ-002 SHALL have ports: clk in 1 system clock; rstn in 1 reset; one clock, reset asynchronous active-low.
REQ-003 move in 4 direction request, bit0 up, bit1 down, bit2 left, bit3 right.
REQ-004 cheat_hp in 1, cheat_key in 1: debug increments, active-high.
REQ-005 player_x, player_y out COORD_W position; floor out 16; health out HP_W; key_num out KEY_TYPES*KEY_W, type k at bits [k*KEY_W +: KEY_W].
REQ-006 busy out 1 move in progress; dead out 1 health reached 0.
REQ-007 bram_addr out ADDR_W; bram_data in 16; bram_wr out 1; bram_dwrite out 16; read latency 1 cycle.

Function
REQ-008 SHALL accept a move only in IDLE, on a cycle where move is one-hot and differs from the previous cycle's move sample (edge detect); zero or multi-bit move SHALL be ignored.
REQ-009 Target = position +/-1 on one axis; target outside 0..MAP_W-1 / 0..MAP_H-1 SHALL be rejected in IDLE with no BRAM access, busy stays 0.
REQ-010 FSM states IDLE -> READ -> DECIDE -> (WRITE) -> IDLE; DEAD is absorbing until reset.
REQ-011 READ (cycle N+1): bram_addr = floor*MAP_W*MAP_H + ty*MAP_W + tx; busy=1 from N+1 until return to IDLE.
REQ-012 DECIDE (N+2): sample bram_data; tile type = data[7:0], argument = data[15:8]; updated outputs visible at N+3.
REQ-013 Tile actions: EMPTY move; WALL reject; KEY_k move, key_k+1, clear tile; DOOR_k with key_k>0 move, key_k-1, clear tile, else reject; POTION move, health+arg, clear tile; MONSTER move, health-arg, clear tile; STAIR_UP floor+1; STAIR_DOWN floor-1; unknown code treated as WALL.
REQ-014 Stairs SHALL keep x,y unchanged; STAIR_UP at floor FLOORS-1 or STAIR_DOWN at floor 0 SHALL be rejected.
REQ-015 Clear-tile actions SHALL enter WRITE (N+3): bram_wr=1 one cycle, same address, bram_dwrite=16'h0000; otherwise DECIDE returns to IDLE.
REQ-016 Key and health additions SHALL saturate at all-ones; key decrement never below 0.
REQ-017 MONSTER with arg >= health SHALL set health=0, dead=1, position unchanged, tile not cleared, FSM to DEAD; no further moves or cheats.
REQ-018 In IDLE with no accepted move: cheat_hp adds 1 to health (saturating) each cycle asserted; else cheat_key adds 1 to every key type (saturating); cheat_hp has priority; cheats ignored when not IDLE.
REQ-019 move changes while busy SHALL be ignored, but the edge-detect register SHALL keep sampling.
REQ-020 bram_wr SHALL be 0 in all states except WRITE.

Reset
REQ-021 On rstn low, immediately: player_x=START_X, player_y=START_Y, floor=0, health=START_HP, key_num=0, dead=0, busy=0, bram_wr=0, bram_addr=0, bram_dwrite=0, FSM=IDLE, edge register=0.
REQ-022 Reset mid-move SHALL abort without the pending BRAM write.

Structure
REQ-023 Tile codes (EMPTY 0x00, WALL 0x01, KEY_k 0x02+k, DOOR_k 0x10+k, POTION 0x20, MONSTER 0x30, STAIR_UP 0x40, STAIR_DOWN 0x41) and FSM state encodings SHALL live in shared package tile_pkg.
REQ-024 Direction decode, bounds check and address computation SHALL be one combinational sub-module, player_target.

Verification
REQ-025 After reset, move=0001 for one cycle with target tile EMPTY -> player_y=9 visible 3 cycles after edge; bram_wr never asserted.
REQ-026 Target tile 0x0003 (KEY_1) -> key_num[15:8]=1, bram_wr pulse with dwrite=0 at the target address; then DOOR_1 (0x0011) -> key type 1 back to 0, player moves, door cleared.
REQ-027 DOOR_2 with key type 2=0 -> position, keys, and map unchanged; busy returns to 0 after DECIDE.
REQ-028 health=20, MONSTER arg=5 (0x0530) -> health 15, player moves; MONSTER arg=20 -> health 0, dead=1, later moves and cheats ignored.
REQ-029 At x=0, move=0100 -> no BRAM read, busy stays 0; STAIR_DOWN on floor 0 rejected; STAIR_UP on floor 0 -> floor 1, x,y unchanged.
REQ-030 key type 0=255 plus cheat_key -> stays 255; rstn pulsed during WRITE -> no write, all outputs at reset values.
